// File: rtl/bht_pkg.sv
// Shared types and helpers for the set-associative branch history table:
// FSM states, saturating counter step and tree pseudo-LRU maths.
package bht_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } bht_state_t;

    // Deepest PLRU tree the helpers handle (32 ways).
    localparam int MAX_LG = 5;

    function automatic logic [31:0] sat_next(
        input logic [31:0] cnt,
        input logic        dir,
        input int unsigned width
    );
        logic [31:0] top;
        top = (32'd1 << width) - 32'd1;
        if (dir) begin
            sat_next = (cnt == top) ? cnt : cnt + 32'd1;
        end else begin
            sat_next = (cnt == 32'd0) ? cnt : cnt - 32'd1;
        end
    endfunction

    // Heap-ordered tree: node n has children 2n and 2n+1, bit n-1 holds it.
    function automatic logic [31:0] plru_touch(
        input logic [31:0] bits,
        input int unsigned way,
        input int unsigned lg
    );
        logic [31:0] b;
        int unsigned node;
        logic        dir;
        b    = bits;
        node = 1;
        for (int l = MAX_LG - 1; l >= 0; l--) begin
            if (l < int'(lg)) begin
                dir             = ((way >> l) & 32'd1) != 32'd0;
                b[5'(node - 1)] = ~dir;
                node            = 2 * node + (dir ? 32'd1 : 32'd0);
            end
        end
        plru_touch = b;
    endfunction

    function automatic int unsigned plru_victim(
        input logic [31:0] bits,
        input int unsigned lg
    );
        int unsigned node;
        node = 1;
        for (int l = 0; l < MAX_LG; l++) begin
            if (l < int'(lg)) begin
                node = 2 * node + (bits[5'(node - 1)] ? 32'd1 : 32'd0);
            end
        end
        plru_victim = node - (32'd1 << lg);
    endfunction

endpackage

// File: rtl/bht_set.sv
// One set of the branch history table: tags, valids, counters and PLRU bits,
// with clear, read-touch, update-hit and allocate controls.
module bht_set
    import bht_pkg::*;
#(
    parameter int TAG_LEN    = 7,
    parameter int WAYS       = 4,
    parameter int COUNT_LEN  = 2,
    parameter int COUNT_INIT = 1
) (
    input  logic                                clk,
    input  logic                                clr,
    input  logic                                rd_touch,
    input  logic [$clog2(WAYS)-1:0]             rd_way,
    input  logic                                upd_hit,
    input  logic                                upd_alloc,
    input  logic [$clog2(WAYS)-1:0]             upd_way,
    input  logic [TAG_LEN-1:0]                  upd_tag,
    input  logic                                upd_taken,
    output logic [WAYS-1:0][TAG_LEN-1:0]        tags,
    output logic [WAYS-1:0]                     valid,
    output logic [WAYS-1:0][COUNT_LEN-1:0]      counts,
    output logic [WAYS-2:0]                     plru
);

    localparam int WLG = $clog2(WAYS);
    localparam logic [COUNT_LEN-1:0] INIT   = COUNT_LEN'(COUNT_INIT);
    localparam logic [COUNT_LEN-1:0] INIT_T = COUNT_LEN'(COUNT_INIT + 1);
    localparam logic [COUNT_LEN-1:0] INIT_N = COUNT_LEN'(COUNT_INIT - 1);

    logic [WAYS-2:0] plru_nxt;
    logic [31:0]     pt;

    // Read touch first, so shared path bits end up with the update's value.
    always_comb begin
        pt = '0;
        pt[WAYS-2:0] = plru;
        if (rd_touch) begin
            pt = plru_touch(pt, 32'(rd_way), WLG);
        end
        if (upd_hit || upd_alloc) begin
            pt = plru_touch(pt, 32'(upd_way), WLG);
        end
        plru_nxt = pt[WAYS-2:0];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
            plru  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                counts[w] <= INIT;
            end
        end else begin
            plru <= plru_nxt;
            if (upd_alloc) begin
                tags[upd_way]   <= upd_tag;
                valid[upd_way]  <= 1'b1;
                counts[upd_way] <= upd_taken ? INIT_T : INIT_N;
            end else if (upd_hit) begin
                counts[upd_way] <= COUNT_LEN'(sat_next(
                    32'(counts[upd_way]), upd_taken, COUNT_LEN));
            end
        end
    end

endmodule

// File: rtl/assoc_branch_history_table.sv
// N-way set-associative branch history table with tree PLRU replacement,
// 1-cycle registered lookup, allocate-on-miss update and clear sweep FSM.
module assoc_branch_history_table
    import bht_pkg::*;
#(
    parameter int INDEX_LEN  = 7,
    parameter int TAG_LEN    = 7,
    parameter int WAYS       = 4,
    parameter int COUNT_LEN  = 2,
    parameter int COUNT_INIT = 2**(COUNT_LEN-1)-1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    output logic                 ready,
    input  logic                 rd_valid,
    input  logic [INDEX_LEN-1:0] rd_index,
    input  logic [TAG_LEN-1:0]   rd_tag,
    output logic                 rd_resp_valid,
    output logic                 rd_hit,
    output logic [COUNT_LEN-1:0] rd_count,
    output logic                 rd_pred,
    input  logic                 upd_valid,
    input  logic [INDEX_LEN-1:0] upd_index,
    input  logic [TAG_LEN-1:0]   upd_tag,
    input  logic                 upd_taken
);

    localparam int SETS = 2**INDEX_LEN;
    localparam int WLG  = $clog2(WAYS);
    localparam logic [COUNT_LEN-1:0] INIT = COUNT_LEN'(COUNT_INIT);

    bht_state_t           state, state_nxt;
    logic [INDEX_LEN-1:0] clr_ptr, clr_ptr_nxt;

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        unique case (state)
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == '1) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
        if (flush) begin
            state_nxt   = CLEAR;
            clr_ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    logic [WAYS-1:0][TAG_LEN-1:0]   set_tags   [SETS];
    logic [WAYS-1:0]                set_valid  [SETS];
    logic [WAYS-1:0][COUNT_LEN-1:0] set_counts [SETS];
    logic [WAYS-2:0]                set_plru   [SETS];

    logic                 rd_pend;
    logic [INDEX_LEN-1:0] rd_idx_q;
    logic [TAG_LEN-1:0]   rd_tag_q;
    logic                 hold_hit;
    logic [COUNT_LEN-1:0] hold_count;

    logic [WAYS-1:0]      rd_match;
    logic                 rd_hit_c;
    logic [WLG-1:0]       rd_way;
    logic [COUNT_LEN-1:0] rd_count_c;

    always_comb begin
        rd_match = '0;
        rd_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_match[w] = set_valid[rd_idx_q][w] &&
                          (set_tags[rd_idx_q][w] == rd_tag_q);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_match[w]) begin
                rd_way = WLG'(w);
            end
        end
        rd_hit_c   = (state == IDLE) && (|rd_match);
        rd_count_c = rd_hit_c ? set_counts[rd_idx_q][rd_way] : INIT;
    end

    // Responses are held between pulses of rd_resp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend    <= 1'b0;
            rd_idx_q   <= '0;
            rd_tag_q   <= '0;
            hold_hit   <= 1'b0;
            hold_count <= INIT;
        end else begin
            rd_pend <= rd_valid;
            if (rd_valid) begin
                rd_idx_q <= rd_index;
                rd_tag_q <= rd_tag;
            end
            if (rd_pend) begin
                hold_hit   <= rd_hit_c;
                hold_count <= rd_count_c;
            end
        end
    end

    assign ready         = (state == IDLE);
    assign rd_resp_valid = rd_pend;
    assign rd_hit        = rd_pend ? rd_hit_c : hold_hit;
    assign rd_count      = rd_pend ? rd_count_c : hold_count;
    assign rd_pred       = rd_count[COUNT_LEN-1];

    logic            upd_en;
    logic [WAYS-1:0] u_match;
    logic            u_hit;
    logic [WLG-1:0]  u_hit_way, u_inv_way, u_way;

    always_comb begin
        upd_en    = upd_valid && (state == IDLE);
        u_match   = '0;
        u_hit_way = '0;
        u_inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            u_match[w] = set_valid[upd_index][w] &&
                         (set_tags[upd_index][w] == upd_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (u_match[w]) begin
                u_hit_way = WLG'(w);
            end
            if (!set_valid[upd_index][w]) begin
                u_inv_way = WLG'(w);
            end
        end
        u_hit = |u_match;
        if (u_hit) begin
            u_way = u_hit_way;
        end else if (!(&set_valid[upd_index])) begin
            u_way = u_inv_way;
        end else begin
            u_way = WLG'(plru_victim(32'(set_plru[upd_index]), WLG));
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        logic clr_sel, rd_sel, upd_sel;

        assign clr_sel = (state == CLEAR) && (clr_ptr == INDEX_LEN'(s));
        assign rd_sel  = rd_pend && rd_hit_c && (rd_idx_q == INDEX_LEN'(s));
        assign upd_sel = upd_en && (upd_index == INDEX_LEN'(s));

        bht_set #(
            .TAG_LEN    (TAG_LEN),
            .WAYS       (WAYS),
            .COUNT_LEN  (COUNT_LEN),
            .COUNT_INIT (COUNT_INIT)
        ) u_set (
            .clk       (clk),
            .clr       (clr_sel),
            .rd_touch  (rd_sel),
            .rd_way    (rd_way),
            .upd_hit   (upd_sel && u_hit),
            .upd_alloc (upd_sel && !u_hit),
            .upd_way   (u_way),
            .upd_tag   (upd_tag),
            .upd_taken (upd_taken),
            .tags      (set_tags[s]),
            .valid     (set_valid[s]),
            .counts    (set_counts[s]),
            .plru      (set_plru[s])
        );
    end

endmodule

// File: doc/assoc_branch_history_table.md
# assoc_branch_history_table

Parametrised N-way set-associative branch history table that replaces the fixed 2-way, 2-bit table in the branch predictor. It is indexed by low PC bits and tagged by the next PC bits. Each way holds a COUNT_LEN-bit saturating counter, and victims are chosen by a tree pseudo-LRU. A fetch-side lookup port is registered with 1-cycle latency, an execute-side update port allocates on miss, and a flush/clear sweep state machine invalidates the table after reset or on a misprediction-storm flush.

## Interface
- INDEX_LEN, 7, set-index width; SETS = 2**INDEX_LEN
- TAG_LEN, 7, tag width
- WAYS, 4, associativity; power of two, ≥2
- COUNT_LEN, 2, saturating counter width, ≥2
- COUNT_INIT, 2**(COUNT_LEN-1)-1, counter value on miss/clear (weakly not-taken)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  start clear sweep
- ready  out  1  1 = IDLE; 0 = clear sweep in progress
- rd_valid  in  1  lookup request
- rd_index  in  INDEX_LEN  lookup set
- rd_tag  in  TAG_LEN  lookup tag
- rd_resp_valid  out  1  response valid (rd_valid delayed 1 cycle)
- rd_hit  out  1  tag found in a valid way
- rd_count  out  COUNT_LEN  hit way counter, else COUNT_INIT
- rd_pred  out  1  rd_count MSB (predict taken)
- upd_valid  in  1  resolved branch update
- upd_index  in  INDEX_LEN  update set
- upd_tag  in  TAG_LEN  update tag
- upd_taken  in  1  1 = increment, 0 = decrement

## Operation
- FSM states CLEAR and IDLE, with a sweep pointer clr_ptr[INDEX_LEN-1:0].
- reset: FSM enters CLEAR, clr_ptr=0, rd_resp_valid=0, rd_hit=0, rd_count=COUNT_INIT, rd_pred=COUNT_INIT MSB, ready=0.
- CLEAR: each cycle set clr_ptr is cleared (all valid=0, counters=COUNT_INIT, PLRU bits=0) and clr_ptr increments. After clearing set SETS-1 the FSM goes to IDLE.
- flush in any state: FSM goes to CLEAR with clr_ptr=0. A flush during CLEAR restarts the sweep.
- Lookup:
  - rd_index/rd_tag are registered when rd_valid=1.
  - In the next cycle, tags of the registered set are compared and outputs are driven combinationally from the register.
  - Outputs are held between responses; rd_resp_valid pulses.
  - A lookup whose response cycle falls in CLEAR returns hit=0, count=COUNT_INIT.
- Update, IDLE only (ignored in CLEAR):
  - Hit: the counter saturates. Increment stops at 2**COUNT_LEN-1 and decrement stops at 0.
  - Miss: allocate a victim. Use the lowest-numbered invalid way if any, else the tree-PLRU victim. Write the tag, set valid=1, and set the counter to COUNT_INIT+1 if upd_taken, else COUNT_INIT-1.
- PLRU: WAYS-1 bits per set, standard binary tree; bit=0 points left as victim.
  - Touching a way sets the path bits to point away from it.
  - Touches come from a lookup hit (in its response cycle) and from an update hit or allocation.
  - Read touch and update touch in the same set, same cycle: apply the read touch first, then the update touch. Shared path bits take the update's value.
- Tag match on more than one valid way cannot occur, because allocation only happens on miss.

## Timing
- Lookup latency is 1 cycle. The response in cycle t+1 reflects every update applied at edges ≤ the end of cycle t. This includes an update presented in cycle t to the same index/tag (no stale read).
- An update presented in cycle t+1 is not visible in the cycle-t+1 response.
- Update commits at the end of the cycle it is presented.
- ready drops in the cycle after the flush/reset edge.
- After a clear starting with clr_ptr=0 at edge e, ready=1 from edge e+SETS.
- Reset mid-sweep or mid-lookup: the pending response is discarded (rd_resp_valid=0 next cycle) and the sweep restarts.

## Structure
- Package bht_pkg holds:
  - the FSM state typedef (CLEAR, IDLE);
  - a sat_next function (counter, dir, width) for saturating counter arithmetic;
  - PLRU touch and victim functions, parameterised by WAYS.
- Sub-module bht_set holds one set's WAYS tags, valids, counters and PLRU bits, with clear, read-touch, update and allocate controls. It is instantiated SETS times in a generate loop.
- The top level holds the FSM, the lookup register, the one-hot index decoders and the output mux.

## Test plan
- Reset, hold idle: ready=0 for 128 cycles then 1. A lookup on (index 5, tag 9) gives hit=0, count=01, pred=0.
- Update (5, 9, taken) → lookup next cycle: hit=1, count=10. Three more taken updates → count=11 (saturates). Five not-taken updates → count=00.
- WAYS=4, updates to set 3 with tags 1, 2, 3, 4 fill ways 0–3. A lookup hit on tag 1, then allocating tag 5, evicts tag 3. Lookups for tags 1, 2, 4, 5 hit; tag 3 misses.
- Update (7, 2, taken) in cycle t with lookup (7, 2) in cycle t → response at t+1 shows hit=1, count=10.
- Flush during steady traffic: ready=0 next cycle; updates are ignored during CLEAR; afterwards every prior entry misses with count=01.
- Reset asserted mid-sweep at clr_ptr=60: sweep restarts; ready returns exactly 128 cycles after reset deasserts.
